halt_monitor: RTL and testbench

HALT_MONITOR -- requirements
Module: halt_monitor

---
 rtl/halt_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_halt_monitor.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halt_monitor.sv
// Halt monitor for a RISC-V style core: watches the commit stream, detects
// halt conditions (ebreak, illegal encodings, instruction limit, watchdog),
// drains for a fixed number of cycles and then asserts halt. It also keeps
// retired/cycle counters and a small ring buffer of recently retired PCs.
module halt_monitor #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned TRACE_DEPTH  = 16,
  parameter int unsigned WDT_LIMIT    = 1000,
  parameter int unsigned INST_LIMIT   = 0,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           commit_valid,
  input  logic [XLEN-1:0]                commit_pc,
  input  logic [31:0]                    commit_inst,
  input  logic [XLEN-1:0]                a0,
  output logic                           halt,
  output logic [2:0]                     halt_cause,
  output logic [31:0]                    halt_code,
  output logic [XLEN-1:0]                halt_pc,
  output logic [63:0]                    inst_count,
  output logic [63:0]                    cycle_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

  localparam int unsigned IDX_W   = $clog2(TRACE_DEPTH);
  // Idle counter only needs to reach WDT_LIMIT-1; it wraps harmlessly when disabled.
  localparam int unsigned IDLE_W  = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd2;
  localparam logic [2:0] CAUSE_LIMIT   = 3'd3;
  localparam logic [2:0] CAUSE_WDT     = 3'd4;

  localparam logic [31:0]        INST_EBREAK = 32'h0010_0073;
  localparam logic [IDX_W:0]     TC_FULL     = (IDX_W+1)'(TRACE_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 32'd1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST   = IDLE_W'(WDT_LIMIT - 32'd1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_r;
  logic                halt_r;
  logic [2:0]          cause_r;
  logic [31:0]         code_r;
  logic [XLEN-1:0]     hpc_r;
  logic [63:0]         inst_cnt_r;
  logic [63:0]         cyc_cnt_r;
  logic [IDLE_W-1:0]   idle_r;
  logic [DRAIN_W-1:0]  drain_r;
  logic [XLEN-1:0]     last_pc_r;
  logic [IDX_W-1:0]    wr_ptr_r;
  logic [IDX_W:0]      tcount_r;
  logic [XLEN-1:0]     ring_r [TRACE_DEPTH];

  logic                is_ebreak_s;
  logic                is_illegal_s;
  logic                lim_hit_s;
  logic                wdt_hit_s;
  logic                trig_s;
  logic [2:0]          trig_cause_s;
  logic [31:0]         trig_code_s;
  logic [XLEN-1:0]     trig_pc_s;
  logic [IDX_W-1:0]    rd_slot_s;

  // Only the low word of a0 is captured as exit code; upper bits are intentionally ignored.
  if (XLEN > 32) begin : g_a0_hi
    logic unused_a0_hi_s;
    assign unused_a0_hi_s = ^a0[XLEN-1:32];
  end

  // Decode halt triggers and resolve them by priority into one cause/code/pc.
  always_comb begin
    is_ebreak_s  = commit_valid && (commit_inst == INST_EBREAK);
    is_illegal_s = commit_valid && ((commit_inst == 32'h0000_0000) || (commit_inst == 32'hFFFF_FFFF));
    if (INST_LIMIT != 32'd0) begin
      lim_hit_s = commit_valid && ((inst_cnt_r + 64'd1) == 64'(INST_LIMIT));
    end else begin
      lim_hit_s = 1'b0;
    end
    // The watchdog expires on the WDT_LIMIT-th cycle since the last commit,
    // even if a commit happens in that very cycle.
    if (WDT_LIMIT != 32'd0) begin
      wdt_hit_s = (idle_r == IDLE_LAST);
    end else begin
      wdt_hit_s = 1'b0;
    end
    trig_s       = is_ebreak_s || is_illegal_s || lim_hit_s || wdt_hit_s;
    trig_cause_s = CAUSE_NONE;
    trig_code_s  = 32'h0000_0000;
    trig_pc_s    = commit_pc;
    if (is_ebreak_s) begin
      trig_cause_s = CAUSE_EBREAK;
      trig_code_s  = a0[31:0];
    end else if (is_illegal_s) begin
      trig_cause_s = CAUSE_ILLEGAL;
      trig_code_s  = 32'hFFFF_FFFF;
    end else if (lim_hit_s) begin
      trig_cause_s = CAUSE_LIMIT;
      trig_code_s  = 32'h0000_0001;
    end else if (wdt_hit_s) begin
      trig_cause_s = CAUSE_WDT;
      trig_code_s  = 32'h0000_0002;
      trig_pc_s    = last_pc_r;
    end else begin
      trig_cause_s = CAUSE_NONE;
    end
  end

  // Run/drain/halted sequencing, counters, ring pointers and latched halt info.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_RUN;
      halt_r     <= 1'b0;
      cause_r    <= CAUSE_NONE;
      code_r     <= 32'h0000_0000;
      hpc_r      <= {XLEN{1'b0}};
      inst_cnt_r <= 64'd0;
      cyc_cnt_r  <= 64'd0;
      idle_r     <= {IDLE_W{1'b0}};
      drain_r    <= {DRAIN_W{1'b0}};
      last_pc_r  <= {XLEN{1'b0}};
      wr_ptr_r   <= {IDX_W{1'b0}};
      tcount_r   <= {(IDX_W+1){1'b0}};
    end else begin
      case (state_r)
        S_RUN: begin
          cyc_cnt_r <= cyc_cnt_r + 64'd1;
          if (commit_valid) begin
            inst_cnt_r <= inst_cnt_r + 64'd1;
            idle_r     <= {IDLE_W{1'b0}};
            last_pc_r  <= commit_pc;
            wr_ptr_r   <= wr_ptr_r + IDX_W'(1);
            if (tcount_r != TC_FULL) begin
              tcount_r <= tcount_r + (IDX_W+1)'(1);
            end
          end else begin
            idle_r <= idle_r + IDLE_W'(1);
          end
          if (trig_s) begin
            cause_r <= trig_cause_s;
            code_r  <= trig_code_s;
            hpc_r   <= trig_pc_s;
            drain_r <= {DRAIN_W{1'b0}};
            state_r <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_r == DRAIN_LAST) begin
            state_r <= S_HALTED;
            halt_r  <= 1'b1;
          end else begin
            drain_r <= drain_r + DRAIN_W'(1);
          end
        end
        S_HALTED: begin
          state_r <= S_HALTED;
        end
        default: begin
          // Corrupted state: stop the core rather than resume running.
          state_r <= S_HALTED;
          halt_r  <= 1'b1;
        end
      endcase
    end
  end

  // Ring storage: record the PC of every commit counted in RUN (contents not reset).
  always_ff @(posedge clock) begin
    if (!reset && (state_r == S_RUN) && commit_valid) begin
      ring_r[wr_ptr_r] <= commit_pc;
    end
  end

  // Combinational ring read, most recent entry at index 0; unfilled slots read 0.
  always_comb begin
    rd_slot_s = wr_ptr_r - IDX_W'(1) - trace_rd_idx;
    if ({1'b0, trace_rd_idx} < tcount_r) begin
      trace_rd_pc = ring_r[rd_slot_s];
    end else begin
      trace_rd_pc = {XLEN{1'b0}};
    end
  end

  assign halt        = halt_r;
  assign halt_cause  = cause_r;
  assign halt_code   = code_r;
  assign halt_pc     = hpc_r;
  assign inst_count  = inst_cnt_r;
  assign cycle_count = cyc_cnt_r;
  assign trace_count = tcount_r;

endmodule

// File: tb/tb_halt_monitor.sv
// Self-checking bench for halt_monitor. Two instances share the commit stream:
// dut A (TRACE_DEPTH=4, WDT_LIMIT=10) and dut B (INST_LIMIT=3, watchdog off).
module tb_halt_monitor;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = 64'd0;
  logic [31:0] commit_inst = NOP;
  logic [63:0] a0 = 64'd0;
  logic [1:0]  a_idx = 2'd0;
  logic [3:0]  b_idx = 4'd0;

  logic        a_halt, b_halt;
  logic [2:0]  a_halt_cause, b_halt_cause;
  logic [31:0] a_halt_code, b_halt_code;
  logic [63:0] a_halt_pc, b_halt_pc, a_inst_count, b_inst_count, a_cycle_count, b_cycle_count;
  logic [63:0] a_trace_rd_pc, b_trace_rd_pc;
  logic [2:0]  a_trace_count;
  logic [4:0]  b_trace_count;

  int checks = 0;
  int failures = 0;

  halt_monitor #(.XLEN(64), .TRACE_DEPTH(4), .WDT_LIMIT(10), .INST_LIMIT(0), .DRAIN_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .a0(a0), .halt(a_halt), .halt_cause(a_halt_cause),
    .halt_code(a_halt_code), .halt_pc(a_halt_pc), .inst_count(a_inst_count),
    .cycle_count(a_cycle_count), .trace_rd_idx(a_idx), .trace_rd_pc(a_trace_rd_pc),
    .trace_count(a_trace_count));

  halt_monitor #(.XLEN(64), .TRACE_DEPTH(16), .WDT_LIMIT(0), .INST_LIMIT(3), .DRAIN_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .a0(a0), .halt(b_halt), .halt_cause(b_halt_cause),
    .halt_code(b_halt_code), .halt_pc(b_halt_pc), .inst_count(b_inst_count),
    .cycle_count(b_cycle_count), .trace_rd_idx(b_idx), .trace_rd_pc(b_trace_rd_pc),
    .trace_count(b_trace_count));

  always #5 clock = ~clock;

  // Reference model, one slot per instance: a "stopped" flag plus a drain
  // countdown, plain counters, and a history of the most recent retired PCs.
  int          cfg_depth [2] = '{4, 16};
  int          cfg_wdt   [2] = '{10, 0};
  int          cfg_ilim  [2] = '{0, 3};
  int          cfg_drain = 4;
  bit          m_stopped [2];
  bit          m_halted  [2];
  int          m_drain_left [2];
  logic [2:0]  m_cause [2];
  logic [31:0] m_code  [2];
  logic [63:0] m_pc    [2];
  logic [63:0] m_insts [2];
  logic [63:0] m_cycles[2];
  logic [63:0] m_last  [2];
  int          m_idle  [2];
  int          m_n     [2];
  logic [63:0] m_recent [2][16];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_stopped[k] = 1'b0; m_halted[k] = 1'b0; m_drain_left[k] = 0;
      m_cause[k] = 3'd0; m_code[k] = 32'd0; m_pc[k] = 64'd0;
      m_insts[k] = 64'd0; m_cycles[k] = 64'd0; m_last[k] = 64'd0;
      m_idle[k] = 0; m_n[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit eb, il, lim, wd;
    if (m_stopped[k]) begin
      if (!m_halted[k]) begin
        m_drain_left[k]--;
        if (m_drain_left[k] == 0) m_halted[k] = 1'b1;
      end
    end else begin
      eb  = commit_valid && (commit_inst == EBREAK);
      il  = commit_valid && (commit_inst == 32'h0000_0000 || commit_inst == 32'hFFFF_FFFF);
      lim = (cfg_ilim[k] != 0) && commit_valid && (m_insts[k] + 64'd1 == 64'(cfg_ilim[k]));
      wd  = (cfg_wdt[k] != 0) && (m_idle[k] + 1 == cfg_wdt[k]);
      m_cycles[k] += 64'd1;
      if (commit_valid) begin
        m_insts[k] += 64'd1;
        for (int i = 15; i > 0; i--) m_recent[k][i] = m_recent[k][i-1];
        m_recent[k][0] = commit_pc;
        m_n[k]++;
        m_idle[k] = 0;
        m_last[k] = commit_pc;
      end else begin
        m_idle[k]++;
      end
      if (eb || il || lim || wd) begin
        m_stopped[k] = 1'b1;
        m_drain_left[k] = cfg_drain;
        if (eb)       begin m_cause[k] = 3'd1; m_code[k] = a0[31:0];     m_pc[k] = commit_pc; end
        else if (il)  begin m_cause[k] = 3'd2; m_code[k] = 32'hFFFF_FFFF; m_pc[k] = commit_pc; end
        else if (lim) begin m_cause[k] = 3'd3; m_code[k] = 32'h1;        m_pc[k] = commit_pc; end
        else          begin m_cause[k] = 3'd4; m_code[k] = 32'h2;        m_pc[k] = m_last[k]; end
      end
    end
  endtask

  function automatic int exp_count(input int k);
    return (m_n[k] < cfg_depth[k]) ? m_n[k] : cfg_depth[k];
  endfunction

  function automatic logic [63:0] exp_read(input int k, input int idx);
    if (idx < exp_count(k)) return m_recent[k][idx];
    else return 64'd0;
  endfunction

  // One clock: inputs are already applied; advance the model at the edge, sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; commit_valid = 1'b0; commit_inst = NOP;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_commit(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] val);
    commit_valid = 1'b1; commit_pc = pc; commit_inst = inst; a0 = val;
    tick();
    commit_valid = 1'b0; commit_inst = NOP;
  endtask

  task automatic idle_cycles(input int n);
    commit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({a_halt, a_halt_cause, a_halt_code, a_halt_pc, a_inst_count, a_cycle_count, a_trace_count} !== '0) begin
      failures++;
      $display("FAIL reset_a: got halt=%b cause=%0d code=%h inst=%0d cyc=%0d tc=%0d want all zero",
               a_halt, a_halt_cause, a_halt_code, a_inst_count, a_cycle_count, a_trace_count);
    end
    checks++;
    if ({b_halt, b_halt_cause, b_halt_code, b_halt_pc, b_inst_count, b_cycle_count, b_trace_count} !== '0) begin
      failures++;
      $display("FAIL reset_b: got halt=%b cause=%0d inst=%0d cyc=%0d want all zero",
               b_halt, b_halt_cause, b_inst_count, b_cycle_count);
    end
    reset = 1'b0;
    model_clear();
    idle_cycles(1);
    checks++;
    if ({a_cycle_count, a_inst_count} !== {64'd1, 64'd0}) begin
      failures++;
      $display("FAIL reset_first_cycle: got cyc=%0d inst=%0d want cyc=1 inst=0", a_cycle_count, a_inst_count);
    end
  endtask

  task automatic test_ebreak();
    do_reset();
    do_commit(64'h100, NOP, 64'd11);
    do_commit(64'h104, NOP, 64'd12);
    do_commit(64'h108, NOP, 64'd13);
    do_commit(64'h10C, EBREAK, 64'd0);
    checks++;
    if ({a_halt, a_halt_cause, a_halt_code, a_halt_pc} !== {1'b0, 3'd1, 32'd0, 64'h10C}) begin
      failures++;
      $display("FAIL ebreak_latch: got halt=%b cause=%0d code=%h pc=%h want 0/1/0/10c",
               a_halt, a_halt_cause, a_halt_code, a_halt_pc);
    end
    // Commits during drain must be ignored.
    for (int i = 0; i < 3; i++) do_commit(64'h500 + 64'(4*i), NOP, 64'd0);
    checks++;
    if (a_halt !== 1'b0) begin
      failures++; $display("FAIL ebreak_drain3: got halt=%b want 0", a_halt);
    end
    idle_cycles(1);
    checks++;
    if (a_halt !== 1'b1) begin
      failures++; $display("FAIL ebreak_drain4: got halt=%b want 1", a_halt);
    end
    checks++;
    if ({a_inst_count, a_cycle_count, a_trace_count} !== {64'd4, 64'd4, 3'd4}) begin
      failures++;
      $display("FAIL ebreak_counts: got inst=%0d cyc=%0d tc=%0d want 4/4/4", a_inst_count, a_cycle_count, a_trace_count);
    end
    a_idx = 2'd0; #1;
    checks++;
    if (a_trace_rd_pc !== 64'h10C) begin
      failures++; $display("FAIL ebreak_trace0: got %h want 10c", a_trace_rd_pc);
    end
    a_idx = 2'd3; #1;
    checks++;
    if (a_trace_rd_pc !== 64'h100) begin
      failures++; $display("FAIL ebreak_trace3: got %h want 100", a_trace_rd_pc);
    end
  endtask

  task automatic test_ebreak_wdt();
    do_reset();
    idle_cycles(9);
    checks++;
    if (a_halt_cause !== 3'd0) begin
      failures++; $display("FAIL ebwdt_pre: got cause=%0d want 0", a_halt_cause);
    end
    // Tenth cycle without a prior commit: watchdog expires together with ebreak.
    do_commit(64'h600, EBREAK, 64'd5);
    checks++;
    if ({a_halt_cause, a_halt_code, a_halt_pc} !== {3'd1, 32'd5, 64'h600}) begin
      failures++;
      $display("FAIL ebwdt_prio: got cause=%0d code=%h pc=%h want 1/5/600", a_halt_cause, a_halt_code, a_halt_pc);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    do_commit(64'h8000_0010, NOP, 64'd0);
    for (int k = 1; k <= 14; k++) begin
      idle_cycles(1);
      checks++;
      if ({a_halt, a_halt_cause} !== {(k >= 14), ((k >= 10) ? 3'd4 : 3'd0)}) begin
        failures++;
        $display("FAIL wdt_seq k=%0d: got halt=%b cause=%0d want halt=%b cause=%0d",
                 k, a_halt, a_halt_cause, (k >= 14), ((k >= 10) ? 3'd4 : 3'd0));
      end
    end
    checks++;
    if ({a_halt_code, a_halt_pc, a_cycle_count, a_inst_count} !== {32'd2, 64'h8000_0010, 64'd11, 64'd1}) begin
      failures++;
      $display("FAIL wdt_latch: got code=%h pc=%h cyc=%0d inst=%0d want 2/80000010/11/1",
               a_halt_code, a_halt_pc, a_cycle_count, a_inst_count);
    end
  endtask

  task automatic test_trace();
    do_reset();
    do_commit(64'h0, NOP, 64'd0);
    do_commit(64'h4, NOP, 64'd0);
    a_idx = 2'd2; #1;
    checks++;
    if ({a_trace_count, a_trace_rd_pc} !== {3'd2, 64'd0}) begin
      failures++; $display("FAIL trace_partial: got tc=%0d rd=%h want 2/0", a_trace_count, a_trace_rd_pc);
    end
    a_idx = 2'd1; #1;
    checks++;
    if (a_trace_rd_pc !== 64'h0) begin
      failures++; $display("FAIL trace_partial_idx1: got %h want 0", a_trace_rd_pc);
    end
    for (int i = 2; i < 6; i++) do_commit(64'(4*i), NOP, 64'd0);
    checks++;
    if (a_trace_count !== 3'd4) begin
      failures++; $display("FAIL trace_count: got %0d want 4", a_trace_count);
    end
    a_idx = 2'd0; #1;
    checks++;
    if (a_trace_rd_pc !== 64'h14) begin
      failures++; $display("FAIL trace_idx0: got %h want 14", a_trace_rd_pc);
    end
    a_idx = 2'd3; #1;
    checks++;
    if (a_trace_rd_pc !== 64'h08) begin
      failures++; $display("FAIL trace_idx3: got %h want 08", a_trace_rd_pc);
    end
  endtask

  task automatic test_inst_limit();
    do_reset();
    do_commit(64'h200, NOP, 64'd0);
    do_commit(64'h204, NOP, 64'd0);
    do_commit(64'h208, NOP, 64'd0);
    checks++;
    if ({b_halt, b_halt_cause, b_halt_code, b_halt_pc, b_inst_count} !== {1'b0, 3'd3, 32'd1, 64'h208, 64'd3}) begin
      failures++;
      $display("FAIL limit_latch: got halt=%b cause=%0d code=%h pc=%h inst=%0d want 0/3/1/208/3",
               b_halt, b_halt_cause, b_halt_code, b_halt_pc, b_inst_count);
    end
    do_commit(64'h20C, EBREAK, 64'd7);
    checks++;
    if ({b_halt_cause, b_halt_code, b_halt_pc, b_inst_count, b_cycle_count} !== {3'd3, 32'd1, 64'h208, 64'd3, 64'd3}) begin
      failures++;
      $display("FAIL limit_hold: got cause=%0d code=%h pc=%h inst=%0d cyc=%0d want 3/1/208/3/3",
               b_halt_cause, b_halt_code, b_halt_pc, b_inst_count, b_cycle_count);
    end
    idle_cycles(3);
    checks++;
    if (b_halt !== 1'b1) begin
      failures++; $display("FAIL limit_halt: got halt=%b want 1", b_halt);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    do_commit(64'h300, EBREAK, 64'd9);
    idle_cycles(2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_halt, a_halt_cause, a_halt_code, a_halt_pc, a_inst_count, a_cycle_count, a_trace_count} !== '0) begin
      failures++;
      $display("FAIL rst_drain_async: got cause=%0d code=%h pc=%h inst=%0d cyc=%0d tc=%0d want all zero",
               a_halt_cause, a_halt_code, a_halt_pc, a_inst_count, a_cycle_count, a_trace_count);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    do_commit(64'h400, EBREAK, 64'h33);
    checks++;
    if ({a_halt_cause, a_halt_code, a_halt_pc, a_inst_count} !== {3'd1, 32'h33, 64'h400, 64'd1}) begin
      failures++;
      $display("FAIL rst_drain_again: got cause=%0d code=%h pc=%h inst=%0d want 1/33/400/1",
               a_halt_cause, a_halt_code, a_halt_pc, a_inst_count);
    end
    idle_cycles(4);
    checks++;
    if (a_halt !== 1'b1) begin
      failures++; $display("FAIL rst_drain_halt: got halt=%b want 1", a_halt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_halt, a_halt_cause} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL rst_halted_async: got halt=%b cause=%0d want 0/0", a_halt, a_halt_cause);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    int prob, r;
    for (int ep = 0; ep < 9; ep++) begin
      do_reset();
      prob = (ep % 3 == 0) ? 90 : ((ep % 3 == 1) ? 50 : 20);
      for (int cyc = 0; cyc < 150; cyc++) begin
        commit_valid = ($urandom_range(99) < prob);
        r = $urandom_range(99);
        commit_inst = (r < 1) ? EBREAK : (r < 2) ? 32'h0000_0000 : (r < 3) ? 32'hFFFF_FFFF : 32'($urandom);
        commit_pc = {32'($urandom), 32'($urandom)};
        a0 = {32'($urandom), 32'($urandom)};
        a_idx = 2'($urandom_range(3));
        b_idx = 4'($urandom_range(15));
        tick();
        checks++;
        if ({a_halt, a_halt_cause, a_halt_code} !== {m_halted[0], m_cause[0], m_code[0]}) begin
          failures++;
          $display("FAIL rand_a_status ep=%0d cyc=%0d: got %b/%0d/%h want %b/%0d/%h", ep, cyc,
                   a_halt, a_halt_cause, a_halt_code, m_halted[0], m_cause[0], m_code[0]);
        end
        checks++;
        if ({a_halt_pc, a_inst_count, a_cycle_count} !== {m_pc[0], m_insts[0], m_cycles[0]}) begin
          failures++;
          $display("FAIL rand_a_counters ep=%0d cyc=%0d: got pc=%h inst=%0d cyc=%0d want pc=%h inst=%0d cyc=%0d",
                   ep, cyc, a_halt_pc, a_inst_count, a_cycle_count, m_pc[0], m_insts[0], m_cycles[0]);
        end
        checks++;
        if ({a_trace_count, a_trace_rd_pc} !== {3'(exp_count(0)), exp_read(0, int'(a_idx))}) begin
          failures++;
          $display("FAIL rand_a_trace ep=%0d cyc=%0d idx=%0d: got tc=%0d rd=%h want tc=%0d rd=%h", ep, cyc,
                   a_idx, a_trace_count, a_trace_rd_pc, exp_count(0), exp_read(0, int'(a_idx)));
        end
        checks++;
        if ({b_halt, b_halt_cause, b_halt_code, b_halt_pc} !== {m_halted[1], m_cause[1], m_code[1], m_pc[1]}) begin
          failures++;
          $display("FAIL rand_b_status ep=%0d cyc=%0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", ep, cyc,
                   b_halt, b_halt_cause, b_halt_code, b_halt_pc, m_halted[1], m_cause[1], m_code[1], m_pc[1]);
        end
        checks++;
        if ({b_inst_count, b_cycle_count, b_trace_count, b_trace_rd_pc} !==
            {m_insts[1], m_cycles[1], 5'(exp_count(1)), exp_read(1, int'(b_idx))}) begin
          failures++;
          $display("FAIL rand_b_counters ep=%0d cyc=%0d: got inst=%0d cyc=%0d tc=%0d rd=%h want %0d/%0d/%0d/%h",
                   ep, cyc, b_inst_count, b_cycle_count, b_trace_count, b_trace_rd_pc,
                   m_insts[1], m_cycles[1], exp_count(1), exp_read(1, int'(b_idx)));
        end
      end
    end
    commit_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_ebreak();
    test_ebreak_wdt();
    test_watchdog();
    test_trace();
    test_inst_limit();
    test_reset_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
